keypad_entry: RTL and testbench

Reads a 4x4 matrix keypad and assembles a signed decimal entry in the same 8-bit sign-magnitude format the 4-digit scan display consumes: bit 7 is the sign and bits 6:0 are the magnitude, 0..127. The block scans rows, debounces, and decodes one key per press. It maintains a live edit value that can drive the display directly, and emits a one-cycle committed-value pulse on Enter. It is the input-side counterpart of the display path and feeds the CPU I/O.

---
 rtl/keypad_entry_pkg.sv | 29 ++
 rtl/keypad_entry_if.sv | 12 +
 rtl/keypad_decode.sv | 57 +++++
 rtl/keypad_entry.sv | 217 +++++++++++++++++++++
 tb/tb_keypad_entry.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_entry_pkg.sv
// Shared key codes, debounce state encoding and entry limits for keypad_entry.
package keypad_entry_pkg;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_NEG   = 4'd10;
    localparam logic [3:0] KEY_ENTER = 4'd11;
    localparam logic [3:0] KEY_BKSP  = 4'd12;
    localparam logic [3:0] KEY_CLR   = 4'd13;
    localparam logic [3:0] KEY_NOP   = 4'd15;

    localparam int unsigned MAG_MAX = 127;

    typedef enum logic [1:0] {
        StIdle,
        StPressDb,
        StHeld,
        StRelDb
    } db_state_e;

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad matrix pins plus the live/committed entry outputs of keypad_entry.
interface keypad_entry_if;
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] entry;
    logic [7:0] value;
    logic       value_valid;
    logic       err;

    modport master (input row, entry, value, value_valid, err, output col);
    modport slave (output row, entry, value, value_valid, err, input col);
endinterface

// File: rtl/keypad_decode.sv
// Maps the active-low row drive and one row's column sample to {valid, key code}.
module keypad_decode
    import keypad_entry_pkg::*;
(
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic       valid,
    output logic [3:0] key
);

    logic [1:0] r;
    logic [1:0] c;
    logic       row_ok;
    logic       col_ok;

    always_comb begin
        r      = 2'd0;
        c      = 2'd0;
        row_ok = 1'b1;
        col_ok = 1'b1;
        unique case (row)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: row_ok = 1'b0;
        endcase
        unique case (col)
            4'b1110: c = 2'd0;
            4'b1101: c = 2'd1;
            4'b1011: c = 2'd2;
            4'b0111: c = 2'd3;
            default: col_ok = 1'b0;
        endcase
        valid = row_ok & col_ok;

        key = KEY_NOP;
        case ({r, c})
            4'd0:    key = KEY_1;
            4'd1:    key = KEY_2;
            4'd2:    key = KEY_3;
            4'd3:    key = KEY_BKSP;
            4'd4:    key = KEY_4;
            4'd5:    key = KEY_5;
            4'd6:    key = KEY_6;
            4'd7:    key = KEY_CLR;
            4'd8:    key = KEY_7;
            4'd9:    key = KEY_8;
            4'd10:   key = KEY_9;
            4'd12:   key = KEY_NEG;
            4'd13:   key = KEY_0;
            4'd14:   key = KEY_ENTER;
            default: key = KEY_NOP;
        endcase
    end

endmodule

// File: rtl/keypad_entry.sv
// 4x4 keypad scanner with frame debounce and a signed decimal entry editor.
module keypad_entry
    import keypad_entry_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 200000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         rst,
    keypad_entry_if.slave bus
);

    localparam int unsigned     DivW     = $clog2(SCAN_DIV);
    localparam int unsigned     DbW      = $clog2(DEBOUNCE + 1);
    localparam logic [DivW-1:0] DivLast  = DivW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]  DbMax    = DbW'(DEBOUNCE);
    localparam logic [DbW-1:0]  DbOne    = DbW'(1);
    localparam bit              DbSingle = (DEBOUNCE == 1);
    localparam logic [10:0]     ProdMax  = 11'(MAG_MAX);

    logic [3:0]      col_meta_q, col_sync_q;
    logic [DivW-1:0] div_q;
    logic [1:0]      row_idx_q;
    logic [3:0]      row_drv;
    logic            slot_end, frame_end;

    assign row_drv   = ~(4'b0001 << row_idx_q);
    assign slot_end  = (div_q == DivLast);
    assign frame_end = slot_end && (row_idx_q == 2'd3);

    logic       dec_valid;
    logic [3:0] dec_key;

    keypad_decode u_decode (
        .row   (row_drv),
        .col   (col_sync_q),
        .valid (dec_valid),
        .key   (dec_key)
    );

    // Per-frame hit count saturates at 2; anything but exactly 1 is treated as no key.
    logic [1:0] hits_q, acc_hits;
    logic [3:0] code_q, acc_code;
    logic       frame_single;

    always_comb begin
        acc_hits = hits_q;
        acc_code = code_q;
        if (col_sync_q != 4'hF) begin
            if (dec_valid && hits_q == 2'd0) begin
                acc_hits = 2'd1;
                acc_code = dec_key;
            end else begin
                acc_hits = 2'd2;
            end
        end
        frame_single = (acc_hits == 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_meta_q <= 4'hF;
            col_sync_q <= 4'hF;
            div_q      <= '0;
            row_idx_q  <= 2'd0;
            hits_q     <= 2'd0;
            code_q     <= KEY_NOP;
        end else begin
            col_meta_q <= bus.col;
            col_sync_q <= col_meta_q;
            if (slot_end) begin
                div_q     <= '0;
                row_idx_q <= row_idx_q + 2'd1;
                hits_q    <= frame_end ? 2'd0 : acc_hits;
                code_q    <= acc_code;
            end else begin
                div_q <= div_q + 1'b1;
            end
        end
    end

    db_state_e      state_q, state_d;
    logic [DbW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]     cand_q, cand_d;
    logic           evt;
    logic           key_evt_q;
    logic [3:0]     key_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        evt     = 1'b0;
        cnt_inc = cnt_q + 1'b1;
        if (frame_end) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_single) begin
                        cand_d  = acc_code;
                        cnt_d   = DbOne;
                        evt     = DbSingle;
                        state_d = DbSingle ? StHeld : StPressDb;
                    end
                end
                StPressDb: begin
                    if (frame_single && acc_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbMax) begin
                            evt     = 1'b1;
                            state_d = StHeld;
                        end
                    end else begin
                        state_d = StIdle;
                    end
                end
                StHeld: begin
                    if (!frame_single) begin
                        cnt_d   = DbOne;
                        state_d = DbSingle ? StIdle : StRelDb;
                    end
                end
                StRelDb: begin
                    if (frame_single) begin
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DbMax) state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    logic       sign_q, sign_d;
    logic [6:0] mag_q, mag_d;
    logic [1:0] dig_q, dig_d;
    logic [7:0] value_q, value_d;
    logic       vv_q, vv_d, err_q, err_d;
    logic [10:0] prod;

    always_comb begin
        sign_d  = sign_q;
        mag_d   = mag_q;
        dig_d   = dig_q;
        value_d = value_q;
        vv_d    = 1'b0;
        err_d   = 1'b0;
        prod    = 11'(mag_q) * 11'd10 + 11'(key_q);
        if (key_evt_q) begin
            case (key_q)
                KEY_NEG: sign_d = ~sign_q;
                KEY_BKSP: begin
                    mag_d = mag_q / 7'd10;
                    if (dig_q != 2'd0) dig_d = dig_q - 2'd1;
                end
                KEY_CLR: begin
                    sign_d = 1'b0;
                    mag_d  = '0;
                    dig_d  = '0;
                end
                KEY_ENTER: begin
                    value_d = {sign_q & (mag_q != 7'd0), mag_q};
                    vv_d    = 1'b1;
                    sign_d  = 1'b0;
                    mag_d   = '0;
                    dig_d   = '0;
                end
                default: begin
                    if (key_q <= KEY_9) begin
                        if (dig_q == 2'd3 || prod > ProdMax) begin
                            err_d = 1'b1;
                        end else begin
                            mag_d = prod[6:0];
                            dig_d = dig_q + 2'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cand_q    <= KEY_NOP;
            key_evt_q <= 1'b0;
            key_q     <= KEY_NOP;
            sign_q    <= 1'b0;
            mag_q     <= '0;
            dig_q     <= '0;
            value_q   <= '0;
            vv_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            key_evt_q <= evt;
            if (evt) key_q <= cand_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            dig_q     <= dig_d;
            value_q   <= value_d;
            vv_q      <= vv_d;
            err_q     <= err_d;
        end
    end

    assign bus.row         = row_drv;
    assign bus.entry       = {sign_q, mag_q};
    assign bus.value       = value_q;
    assign bus.value_valid = vv_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: fixed keystroke table, hand-built corner sequences, random keystrokes.
module tb_keypad_entry;

    localparam int unsigned ScanDiv  = 4;
    localparam int unsigned Debounce = 2;
    localparam int          Frame    = 16;
    localparam int KNeg = 10, KEnter = 11, KBksp = 12, KClr = 13, KNop = 15;

    // Keypad layout, index = row*4 + col.
    int keymap [16] = '{1, 2, 3, KBksp, 4, 5, 6, KClr, 7, 8, 9, KNop, KNeg, 0, KEnter, KNop};

    typedef struct {
        int key;
        int entry;
        int value;
        int vv;
        int err;
    } vec_t;
    vec_t vecs [$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  col_drv;

    keypad_entry_if bus ();
    assign bus.col = col_drv;

    keypad_entry #(.SCAN_DIV(ScanDiv), .DEBOUNCE(Debounce)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !bus.row[r]) col_drv[c] = 1'b0;
    end

    int n_cmp = 0, n_fail = 0;
    int vv_total = 0, err_total = 0;

    always @(negedge clk) begin
        if (bus.value_valid === 1'b1) vv_total++;
        if (bus.err === 1'b1) err_total++;
    end

    int m_sign = 0, m_mag = 0, m_cnt = 0, m_value = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_key(input int k);
        if (k <= 9) begin
            if (m_cnt < 3 && m_mag * 10 + k <= 127) begin
                m_mag = m_mag * 10 + k;
                m_cnt++;
            end
        end else if (k == KNeg) begin
            m_sign = 1 - m_sign;
        end else if (k == KBksp) begin
            m_mag = m_mag / 10;
            if (m_cnt > 0) m_cnt--;
        end else if (k == KClr || k == KEnter) begin
            if (k == KEnter) m_value = (m_sign == 1 && m_mag != 0) ? 128 + m_mag : m_mag;
            m_sign = 0;
            m_mag  = 0;
            m_cnt  = 0;
        end
    endtask

    function automatic int model_err(input int k);
        return (k <= 9 && (m_cnt == 3 || m_mag * 10 + k > 127)) ? 1 : 0;
    endfunction

    function automatic int pos_of(input int k);
        for (int i = 0; i < 16; i++) if (keymap[i] == k) return i;
        return 0;
    endfunction

    // One clean keystroke; returns the pulse counts seen while it ran.
    task automatic stroke(input int k, input int hold_f, input int rel_f,
                          output int got_vv, output int got_err);
        int p, vv0, er0;
        p   = pos_of(k);
        vv0 = vv_total;
        er0 = err_total;
        pressed[p] = 1'b1;
        repeat (hold_f * Frame) @(negedge clk);
        pressed[p] = 1'b0;
        repeat (rel_f * Frame) @(negedge clk);
        got_vv  = vv_total - vv0;
        got_err = err_total - er0;
    endtask

    task automatic add(input int k, input int e, input int v, input int vv, input int er);
        vec_t t;
        t.key = k; t.entry = e; t.value = v; t.vv = vv; t.err = er;
        vecs.push_back(t);
    endtask

    initial begin
        int gvv, gerr, evv, eerr, k, vv0, er0;

        add(1, 'h01, 'h00, 0, 0);      add(2, 'h0C, 'h00, 0, 0);
        add(7, 'h7F, 'h00, 0, 0);      add(KEnter, 'h00, 'h7F, 1, 0);
        add(KNeg, 'h80, 'h7F, 0, 0);   add(4, 'h84, 'h7F, 0, 0);
        add(2, 'hAA, 'h7F, 0, 0);      add(KEnter, 'h00, 'hAA, 1, 0);
        add(KNeg, 'h80, 'hAA, 0, 0);   add(KEnter, 'h00, 'h00, 1, 0);
        add(1, 'h01, 'h00, 0, 0);      add(3, 'h0D, 'h00, 0, 0);
        add(0, 'h0D, 'h00, 0, 1);      add(KBksp, 'h01, 'h00, 0, 0);
        add(KClr, 'h00, 'h00, 0, 0);   add(KBksp, 'h00, 'h00, 0, 0);
        add(0, 'h00, 'h00, 0, 0);      add(0, 'h00, 'h00, 0, 0);
        add(1, 'h01, 'h00, 0, 0);      add(2, 'h01, 'h00, 0, 1);
        add(KNop, 'h01, 'h00, 0, 0);   add(KEnter, 'h00, 'h01, 1, 0);
        add(1, 'h01, 'h01, 0, 0);      add(2, 'h0C, 'h01, 0, 0);
        add(8, 'h0C, 'h01, 0, 1);      add(KNeg, 'h8C, 'h01, 0, 0);
        add(KBksp, 'h81, 'h01, 0, 0);  add(KEnter, 'h00, 'h81, 1, 0);

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset row", bus.row, 4'hE);
        check("reset entry", bus.entry, 8'h00);
        check("reset value", bus.value, 8'h00);
        check("reset value_valid", bus.value_valid, 1'b0);
        check("reset err", bus.err, 1'b0);
        rst = 1'b0;

        // Build some state, then reset asynchronously mid-frame with a press in flight.
        stroke(1, 4, 4, gvv, gerr);
        stroke(KEnter, 4, 4, gvv, gerr);
        stroke(3, 4, 4, gvv, gerr);
        check("pre-reset entry", bus.entry, 8'h03);
        check("pre-reset value", bus.value, 8'h01);
        pressed[1] = 1'b1;
        repeat (Frame + Frame / 2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async reset row", bus.row, 4'hE);
        check("async reset entry", bus.entry, 8'h00);
        check("async reset value", bus.value, 8'h00);
        check("async reset value_valid", bus.value_valid, 1'b0);
        check("async reset err", bus.err, 1'b0);
        pressed = '0;
        m_sign = 0; m_mag = 0; m_cnt = 0; m_value = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] exp_row;
            exp_row = ~(4'b0001 << ((i / ScanDiv) % 4));
            check($sformatf("scan row %0d", i), bus.row, exp_row);
            @(negedge clk);
        end

        // Table of single keystrokes.
        for (int i = 0; i < vecs.size(); i++) begin
            stroke(vecs[i].key, 4, 4, gvv, gerr);
            model_key(vecs[i].key);
            check($sformatf("tbl%0d entry", i), bus.entry, vecs[i].entry);
            check($sformatf("tbl%0d value", i), bus.value, vecs[i].value);
            check($sformatf("tbl%0d value_valid pulses", i), gvv, vecs[i].vv);
            check($sformatf("tbl%0d err pulses", i), gerr, vecs[i].err);
        end

        // Bounce on key 5 for three frames, then held 20 frames: exactly one event.
        vv0 = vv_total; er0 = err_total;
        pressed[5] = 1'b1; repeat (Frame) @(negedge clk);
        pressed[5] = 1'b0; repeat (Frame) @(negedge clk);
        pressed[5] = 1'b1; repeat (4 * Frame) @(negedge clk);
        model_key(5);
        check("bounce entry", bus.entry, 8'h05);
        repeat (16 * Frame) @(negedge clk);
        pressed[5] = 1'b0; repeat (4 * Frame) @(negedge clk);
        check("held no repeat entry", bus.entry, 8'h05);
        check("bounce err pulses", err_total - er0, 0);
        stroke(KClr, 4, 4, gvv, gerr);
        model_key(KClr);
        check("clear after bounce", bus.entry, 8'h00);

        // Keys 1 and 6 together are ignored until 6 is released.
        er0 = err_total;
        pressed[0] = 1'b1; pressed[6] = 1'b1;
        repeat (4 * Frame) @(negedge clk);
        check("two keys entry", bus.entry, 8'h00);
        pressed[6] = 1'b0;
        repeat (3 * Frame) @(negedge clk);
        model_key(1);
        check("after release of 6 entry", bus.entry, 8'h01);
        pressed[0] = 1'b0;
        repeat (4 * Frame) @(negedge clk);
        check("two keys err pulses", err_total - er0, 0);

        // Random keystrokes against the model.
        for (int i = 0; i < 40; i++) begin
            k = keymap[$urandom_range(0, 15)];
            repeat ($urandom_range(0, 15)) @(negedge clk);
            evv  = (k == KEnter) ? 1 : 0;
            eerr = model_err(k);
            stroke(k, $urandom_range(3, 5), $urandom_range(3, 5), gvv, gerr);
            model_key(k);
            check($sformatf("rnd%0d key %0d entry", i, k), bus.entry, m_sign * 128 + m_mag);
            check($sformatf("rnd%0d key %0d value", i, k), bus.value, m_value);
            check($sformatf("rnd%0d key %0d value_valid pulses", i, k), gvv, evv);
            check($sformatf("rnd%0d key %0d err pulses", i, k), gerr, eerr);
        end

        evv = 1;
        stroke(KEnter, 4, 4, gvv, gerr);
        model_key(KEnter);
        check("final value", bus.value, m_value);
        check("final value_valid pulses", gvv, evv);
        check("final entry", bus.entry, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
